// File: rtl/bus_interface_unit_if.sv
// Bus bundle for bus_interface_unit: prefetcher read port, execute-unit
// read/write port and the external single-port memory bus.
// The master modport is the view of the bus interface unit itself; the
// slave modport is the view of everything attached around it.
interface bus_interface_unit_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    // Prefetcher word-read port
    logic              pf_req;
    logic [AW-1:0]     pf_adr;
    logic              pf_ack;
    logic [DW-1:0]     pf_dtr;
    // Execute-unit read/write port
    logic              xu_req;
    logic              xu_we;
    logic [AW-1:0]     xu_adr;
    logic [DW/8-1:0]   xu_be;
    logic [DW-1:0]     xu_wdat;
    logic              xu_ack;
    logic [DW-1:0]     xu_rdat;
    // External memory bus
    logic              mem_cs;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_adr;
    logic [DW-1:0]     mem_wdat;
    logic [DW-1:0]     mem_rdat;
    logic              mem_rdy;

    modport master (
        input  pf_req, pf_adr,
        output pf_ack, pf_dtr,
        input  xu_req, xu_we, xu_adr, xu_be, xu_wdat,
        output xu_ack, xu_rdat,
        output mem_cs, mem_we, mem_be, mem_adr, mem_wdat,
        input  mem_rdat, mem_rdy
    );

    modport slave (
        output pf_req, pf_adr,
        input  pf_ack, pf_dtr,
        output xu_req, xu_we, xu_adr, xu_be, xu_wdat,
        input  xu_ack, xu_rdat,
        input  mem_cs, mem_we, mem_be, mem_adr, mem_wdat,
        output mem_rdat, mem_rdy
    );
endinterface

// File: rtl/bus_interface_unit.sv
// Bus interface unit: arbitrates the prefetcher (PF) word-read port and the
// execute-unit (XU) read/write port onto one external memory bus with
// ready-based wait states. One transfer in flight; a granted transfer always
// runs to completion and pulses its owner's ack, even if the request fell.
module bus_interface_unit #(
    parameter int AW     = 20,
    parameter int DW     = 16,
    parameter bit ARB_RR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_interface_unit_if.master  bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            owner_xu_r, owner_xu_s;   // 1: XU owns the transfer
    logic            last_xu_r, last_xu_s;     // 1: XU was granted last
    logic            pf_ack_r, pf_ack_s;
    logic            xu_ack_r, xu_ack_s;
    logic [DW-1:0]   pf_dtr_r, pf_dtr_s;
    logic [DW-1:0]   xu_rdat_r, xu_rdat_s;
    logic            mem_cs_r, mem_cs_s;
    logic            mem_we_r, mem_we_s;
    logic [BW-1:0]   mem_be_r, mem_be_s;
    logic [AW-1:0]   mem_adr_r, mem_adr_s;
    logic [DW-1:0]   mem_wdat_r, mem_wdat_s;
    logic            grant_xu_s;

    // Arbitration: XU wins when alone, always under fixed priority, and
    // under round-robin only when PF was the previous winner.
    always_comb begin
        grant_xu_s = 1'b0;
        if (bus.xu_req) begin
            if (!bus.pf_req) begin
                grant_xu_s = 1'b1;
            end else if (ARB_RR == 1'b0) begin
                grant_xu_s = 1'b1;
            end else begin
                grant_xu_s = !last_xu_r;
            end
        end else begin
            grant_xu_s = 1'b0;
        end
    end

    // Next-state and next register values; everything holds unless changed.
    always_comb begin
        state_s    = state_r;
        owner_xu_s = owner_xu_r;
        last_xu_s  = last_xu_r;
        pf_ack_s   = 1'b0;
        xu_ack_s   = 1'b0;
        pf_dtr_s   = pf_dtr_r;
        xu_rdat_s  = xu_rdat_r;
        mem_cs_s   = mem_cs_r;
        mem_we_s   = mem_we_r;
        mem_be_s   = mem_be_r;
        mem_adr_s  = mem_adr_r;
        mem_wdat_s = mem_wdat_r;
        case (state_r)
            IDLE: begin
                if (bus.pf_req || bus.xu_req) begin
                    if (grant_xu_s) begin
                        owner_xu_s = 1'b1;
                        last_xu_s  = 1'b1;
                        if (bus.xu_be == {BW{1'b0}}) begin
                            // Nothing to transfer: acknowledge without a bus cycle
                            xu_ack_s = 1'b1;
                            state_s  = ACK;
                        end else begin
                            mem_cs_s   = 1'b1;
                            mem_we_s   = bus.xu_we;
                            mem_be_s   = bus.xu_be;
                            mem_adr_s  = bus.xu_adr;
                            mem_wdat_s = bus.xu_wdat;
                            state_s    = BUSY;
                        end
                    end else begin
                        owner_xu_s = 1'b0;
                        last_xu_s  = 1'b0;
                        mem_cs_s   = 1'b1;
                        mem_we_s   = 1'b0;
                        mem_be_s   = {BW{1'b1}};
                        mem_adr_s  = bus.pf_adr;
                        state_s    = BUSY;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_cs_r && bus.mem_rdy) begin
                    mem_cs_s = 1'b0;
                    mem_we_s = 1'b0;
                    if (!mem_we_r) begin
                        if (owner_xu_r) begin
                            xu_rdat_s = bus.mem_rdat;
                        end else begin
                            pf_dtr_s = bus.mem_rdat;
                        end
                    end else begin
                        xu_rdat_s = xu_rdat_r;
                    end
                    if (owner_xu_r) begin
                        xu_ack_s = 1'b1;
                    end else begin
                        pf_ack_s = 1'b1;
                    end
                    state_s = ACK;
                end else begin
                    state_s = BUSY;
                end
            end
            ACK: begin
                // Ack was high for this one cycle; requests are not sampled here
                state_s = IDLE;
            end
            default: begin
                state_s  = IDLE;
                mem_cs_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_xu_r <= 1'b0;
            last_xu_r  <= 1'b1;   // PF wins the first contested round
            pf_ack_r   <= 1'b0;
            xu_ack_r   <= 1'b0;
            pf_dtr_r   <= {DW{1'b0}};
            xu_rdat_r  <= {DW{1'b0}};
            mem_cs_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_be_r   <= {BW{1'b0}};
            mem_adr_r  <= {AW{1'b0}};
            mem_wdat_r <= {DW{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_xu_r <= owner_xu_s;
            last_xu_r  <= last_xu_s;
            pf_ack_r   <= pf_ack_s;
            xu_ack_r   <= xu_ack_s;
            pf_dtr_r   <= pf_dtr_s;
            xu_rdat_r  <= xu_rdat_s;
            mem_cs_r   <= mem_cs_s;
            mem_we_r   <= mem_we_s;
            mem_be_r   <= mem_be_s;
            mem_adr_r  <= mem_adr_s;
            mem_wdat_r <= mem_wdat_s;
        end
    end

    assign bus.pf_ack   = pf_ack_r;
    assign bus.pf_dtr   = pf_dtr_r;
    assign bus.xu_ack   = xu_ack_r;
    assign bus.xu_rdat  = xu_rdat_r;
    assign bus.mem_cs   = mem_cs_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_be   = mem_be_r;
    assign bus.mem_adr  = mem_adr_r;
    assign bus.mem_wdat = mem_wdat_r;
endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed testbench for bus_interface_unit. Two instances share the same
// stimulus: one round-robin, one XU fixed priority. Completions of the
// round-robin instance are checked against a scoreboard of expected owner/data.
module tb_bus_interface_unit;
    logic clk = 1'b0;
    logic rst;

    logic          pf_req, xu_req, xu_we, mem_rdy;
    logic [19:0]   pf_adr, xu_adr;
    logic [1:0]    xu_be;
    logic [15:0]   xu_wdat, mem_rdat;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        bit          xu;
        logic [15:0] data;
    } sb_t;
    sb_t sb[$];

    bus_interface_unit_if #(.AW(20), .DW(16)) bus_rr ();
    bus_interface_unit_if #(.AW(20), .DW(16)) bus_fp ();

    assign bus_rr.pf_req   = pf_req;   assign bus_fp.pf_req   = pf_req;
    assign bus_rr.pf_adr   = pf_adr;   assign bus_fp.pf_adr   = pf_adr;
    assign bus_rr.xu_req   = xu_req;   assign bus_fp.xu_req   = xu_req;
    assign bus_rr.xu_we    = xu_we;    assign bus_fp.xu_we    = xu_we;
    assign bus_rr.xu_adr   = xu_adr;   assign bus_fp.xu_adr   = xu_adr;
    assign bus_rr.xu_be    = xu_be;    assign bus_fp.xu_be    = xu_be;
    assign bus_rr.xu_wdat  = xu_wdat;  assign bus_fp.xu_wdat  = xu_wdat;
    assign bus_rr.mem_rdat = mem_rdat; assign bus_fp.mem_rdat = mem_rdat;
    assign bus_rr.mem_rdy  = mem_rdy;  assign bus_fp.mem_rdy  = mem_rdy;

    bus_interface_unit #(.AW(20), .DW(16), .ARB_RR(1'b1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    bus_interface_unit #(.AW(20), .DW(16), .ARB_RR(1'b0)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected completion and compare the round-robin instance.
    task automatic check_ack(input string tag);
        sb_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_pf_ack"}, bus_rr.pf_ack, !e.xu);
            chk({tag, "_xu_ack"}, bus_rr.xu_ack, e.xu);
            chk({tag, "_data"}, e.xu ? bus_rr.xu_rdat : bus_rr.pf_dtr, e.data);
        end
    endtask

    initial begin
        rst = 1'b1; pf_req = 1'b0; xu_req = 1'b0; xu_we = 1'b0; mem_rdy = 1'b0;
        pf_adr = 20'h0; xu_adr = 20'h0; xu_be = 2'b00; xu_wdat = 16'h0; mem_rdat = 16'h0;
        step(); step();

        // Reset state
        chk("rst_cs", bus_rr.mem_cs, 1'b0);
        chk("rst_we", bus_rr.mem_we, 1'b0);
        chk("rst_be", bus_rr.mem_be, 2'b00);
        chk("rst_adr", bus_rr.mem_adr, 20'h0);
        chk("rst_wdat", bus_rr.mem_wdat, 16'h0);
        chk("rst_acks", {bus_rr.pf_ack, bus_rr.xu_ack}, 2'b00);
        chk("rst_data", {bus_rr.pf_dtr, bus_rr.xu_rdat}, 32'h0);
        rst = 1'b0;
        step();

        // 1: zero-wait PF read
        pf_req = 1'b1; pf_adr = 20'h00010; mem_rdy = 1'b1; mem_rdat = 16'hBEEF;
        sb.push_back('{1'b0, 16'hBEEF});
        step();
        chk("t1_cs", bus_rr.mem_cs, 1'b1);
        chk("t1_adr", bus_rr.mem_adr, 20'h00010);
        chk("t1_we_be", {bus_rr.mem_we, bus_rr.mem_be}, 3'b011);
        chk("t1_no_ack_yet", {bus_rr.pf_ack, bus_rr.xu_ack}, 2'b00);
        step();
        check_ack("t1");
        chk("t1_cs_off", bus_rr.mem_cs, 1'b0);
        pf_req = 1'b0;
        mem_rdat = 16'h0000;
        step();
        chk("t1_ack_pulse", {bus_rr.pf_ack, bus_rr.xu_ack}, 2'b00);
        chk("t1_dtr_held", bus_rr.pf_dtr, 16'hBEEF);

        // 2: XU write with 3 wait states
        xu_req = 1'b1; xu_we = 1'b1; xu_adr = 20'h0F000; xu_be = 2'b01; xu_wdat = 16'h1234;
        mem_rdy = 1'b0;
        sb.push_back('{1'b1, 16'h0000});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_cs", bus_rr.mem_cs, 1'b1);
            chk("t2_we", bus_rr.mem_we, 1'b1);
            chk("t2_be", bus_rr.mem_be, 2'b01);
            chk("t2_adr", bus_rr.mem_adr, 20'h0F000);
            chk("t2_wdat", bus_rr.mem_wdat, 16'h1234);
            chk("t2_no_ack", bus_rr.xu_ack, 1'b0);
            if (i == 3) mem_rdy = 1'b1;
        end
        step();
        check_ack("t2");
        chk("t2_pf_dtr", bus_rr.pf_dtr, 16'hBEEF);
        chk("t2_we_off", {bus_rr.mem_cs, bus_rr.mem_we}, 2'b00);
        xu_req = 1'b0;
        step();
        chk("t2_ack_pulse", bus_rr.xu_ack, 1'b0);

        // XU zero-wait read
        xu_req = 1'b1; xu_we = 1'b0; xu_adr = 20'h00123; xu_be = 2'b11; mem_rdat = 16'hCAFE;
        sb.push_back('{1'b1, 16'hCAFE});
        step();
        chk("rd_adr", bus_rr.mem_adr, 20'h00123);
        step();
        check_ack("rd");
        chk("rd_pf_dtr", bus_rr.pf_dtr, 16'hBEEF);
        xu_req = 1'b0;
        step();

        // 6: XU with no byte enables -> no bus cycle, ack at N+1
        xu_req = 1'b1; xu_be = 2'b00; mem_rdat = 16'h1111;
        sb.push_back('{1'b1, 16'hCAFE});
        step();
        chk("t6_no_cs", bus_rr.mem_cs, 1'b0);
        check_ack("t6");
        xu_req = 1'b0;
        step();
        chk("t6_ack_pulse", bus_rr.xu_ack, 1'b0);
        chk("t6_no_cs2", bus_rr.mem_cs, 1'b0);

        // 3: both requesting, zero waits
        pf_req = 1'b1; xu_req = 1'b1; pf_adr = 20'h00AAA; xu_adr = 20'h00BBB;
        xu_we = 1'b0; xu_be = 2'b11; mem_rdy = 1'b1; mem_rdat = 16'h5555;
        for (int k = 0; k < 4; k++) sb.push_back('{(k % 2 == 1), 16'h5555});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_rr_adr", bus_rr.mem_adr, (k % 2 == 0) ? 20'h00AAA : 20'h00BBB);
            chk("t3_fp_adr", bus_fp.mem_adr, 20'h00BBB);
            step();
            check_ack("t3_rr");
            chk("t3_fp_acks", {bus_fp.pf_ack, bus_fp.xu_ack}, 2'b01);
            if (k == 3) xu_req = 1'b0;
            step();
        end
        chk("t3_fp_starved", bus_fp.pf_dtr, 16'hBEEF);
        sb.push_back('{1'b0, 16'h5555});
        step();
        chk("t3_fp_pf_adr", bus_fp.mem_adr, 20'h00AAA);
        step();
        check_ack("t3_rr_last");
        chk("t3_fp_pf_ack", {bus_fp.pf_ack, bus_fp.xu_ack}, 2'b10);
        chk("t3_fp_pf_dtr", bus_fp.pf_dtr, 16'h5555);
        pf_req = 1'b0;
        step();

        // 4: PF request dropped during BUSY with 2 wait states
        pf_req = 1'b1; pf_adr = 20'h00222; mem_rdy = 1'b0; mem_rdat = 16'h7777;
        sb.push_back('{1'b0, 16'h7777});
        step();
        chk("t4_cs", bus_rr.mem_cs, 1'b1);
        pf_req = 1'b0;
        step();
        chk("t4_cs_w2", bus_rr.mem_cs, 1'b1);
        step();
        chk("t4_cs_w3", bus_rr.mem_cs, 1'b1);
        mem_rdy = 1'b1;
        step();
        check_ack("t4");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_idle_cs", bus_rr.mem_cs, 1'b0);
            chk("t4_idle_acks", {bus_rr.pf_ack, bus_rr.xu_ack}, 2'b00);
        end

        // 5: reset during BUSY
        xu_req = 1'b1; xu_we = 1'b1; xu_adr = 20'h0ABCD; xu_be = 2'b11; xu_wdat = 16'h9999;
        mem_rdy = 1'b0;
        step();
        chk("t5_cs", bus_rr.mem_cs, 1'b1);
        rst = 1'b1;
        step();
        chk("t5_cs_off", bus_rr.mem_cs, 1'b0);
        chk("t5_regs", {bus_rr.mem_we, bus_rr.mem_be, bus_rr.mem_adr}, 23'h0);
        chk("t5_wdat", bus_rr.mem_wdat, 16'h0);
        chk("t5_data", {bus_rr.pf_dtr, bus_rr.xu_rdat}, 32'h0);
        xu_req = 1'b0; rst = 1'b0; mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_ack", {bus_rr.pf_ack, bus_rr.xu_ack, bus_rr.mem_cs}, 3'b000);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
